// File: rtl/ref_block_fetch_pkg.sv
// Shared defaults, FSM encoding and helpers for the reference-block fetch path.
// Imported by the fetch sequencer and its skid FIFO.
package ref_block_fetch_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_MEMORY_DEPTH = 256;
  localparam int DEF_WINDOW_WIDTH = 16;
  localparam int DEF_BLOCK_SIZE   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // Counter width that stays legal even for a degenerate 1-pixel block.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/ref_block_fetch_skid_fifo.sv
// Two-entry FIFO carrying a pixel plus its first/last block tags.
// Entry 0 is always the head, so the outputs come straight from registers.
module fetch_skid_fifo
  import ref_block_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_push,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  in_pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  out_valid,
  output logic [1:0]            out_count
);

  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0] entry_reg [2];
  logic [1:0]    count_reg;
  logic [EW-1:0] push_entry;
  logic          pop_ok;
  logic          push_ok;

  assign push_entry = {in_last, in_first, in_data};
  assign pop_ok     = in_pop && (count_reg != 2'd0);
  // A push into a full FIFO is dropped unless the head leaves this cycle.
  assign push_ok    = in_push && ((count_reg != 2'd2) || pop_ok);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      count_reg    <= 2'd0;
      entry_reg[0] <= '0;
      entry_reg[1] <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_reg == 2'd0) entry_reg[0] <= push_entry;
          else                   entry_reg[1] <= push_entry;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          entry_reg[0] <= entry_reg[1];
          count_reg    <= count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            entry_reg[0] <= push_entry;
          end else begin
            entry_reg[0] <= entry_reg[1];
            entry_reg[1] <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = entry_reg[0][DATA_WIDTH-1:0];
  assign out_first = entry_reg[0][DATA_WIDTH];
  assign out_last  = entry_reg[0][DATA_WIDTH+1];
  assign out_valid = (count_reg != 2'd0);
  assign out_count = count_reg;

endmodule

// File: rtl/ref_block_fetch.sv
// Read-side sequencer for the reference block memory: walks a BLOCK_SIZE^2
// block at (dx, dy) in the search window and streams the pixels out.
module ref_block_fetch
  import ref_block_fetch_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MEMORY_DEPTH = DEF_MEMORY_DEPTH,
  parameter int WINDOW_WIDTH = DEF_WINDOW_WIDTH,
  parameter int BLOCK_SIZE   = DEF_BLOCK_SIZE
) (
  input  logic                                         in_clk,
  input  logic                                         in_rst,
  input  logic                                         in_start,
  input  logic [$clog2(WINDOW_WIDTH)-1:0]              in_dx,
  input  logic [$clog2(MEMORY_DEPTH/WINDOW_WIDTH)-1:0] in_dy,
  input  logic                                         in_mem_write_busy,
  output logic [$clog2(MEMORY_DEPTH)-1:0]              out_read_addr,
  input  logic [DATA_WIDTH-1:0]                        in_read_data,
  output logic [DATA_WIDTH-1:0]                        out_pixel,
  output logic                                         out_pixel_valid,
  input  logic                                         in_pixel_ready,
  output logic                                         out_first,
  output logic                                         out_last,
  output logic                                         out_busy,
  output logic                                         out_done,
  output logic                                         out_err
);

  localparam int WINDOW_HEIGHT = MEMORY_DEPTH / WINDOW_WIDTH;
  localparam int AW = $clog2(MEMORY_DEPTH);
  localparam int XW = $clog2(WINDOW_WIDTH);
  localparam int YW = $clog2(WINDOW_HEIGHT);
  localparam int BW = clog2_min1(BLOCK_SIZE);

  localparam logic [XW-1:0] DX_MAX     = XW'(WINDOW_WIDTH - BLOCK_SIZE);
  localparam logic [YW-1:0] DY_MAX     = YW'(WINDOW_HEIGHT - BLOCK_SIZE);
  localparam logic [BW-1:0] LAST_IDX   = BW'(BLOCK_SIZE - 1);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(WINDOW_WIDTH);

  fetch_state_t state_reg, state_next;

  logic [XW-1:0] dx_reg;
  logic [YW-1:0] dy_reg;
  logic [BW-1:0] row_reg, row_next;
  logic [BW-1:0] col_reg, col_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic          inflight_reg;
  logic          inflight_first_reg;
  logic          inflight_last_reg;
  logic          done_reg;
  logic          err_reg;

  logic          start_ok;
  logic          start_bad;
  logic          issue;
  logic          pop;
  logic          done_next;
  logic          blk_first;
  logic          blk_last;
  logic [2:0]    occupancy;

  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_first;
  logic                  fifo_last;
  logic                  fifo_valid;
  logic [1:0]            fifo_count;

  function automatic logic [AW-1:0] block_addr(input logic [YW-1:0] y0, input logic [BW-1:0] r,
                                               input logic [XW-1:0] x0, input logic [BW-1:0] c);
    logic [AW-1:0] row_sum;
    logic [AW-1:0] col_sum;
    row_sum = AW'(y0) + AW'(r);
    col_sum = AW'(x0) + AW'(c);
    return row_sum * ROW_STRIDE + col_sum;
  endfunction

  assign start_ok  = (state_reg == ST_IDLE) && in_start && (in_dx <= DX_MAX) && (in_dy <= DY_MAX);
  assign start_bad = (state_reg == ST_IDLE) && in_start && !start_ok;
  assign pop       = fifo_valid && in_pixel_ready;
  assign blk_first = (row_reg == '0) && (col_reg == '0);
  assign blk_last  = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_ok) state_next = ST_FETCH;
      ST_FETCH: if (issue && blk_last) state_next = ST_DRAIN;
      ST_DRAIN: if (done_next) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Occupancy counts what will sit in the FIFO after this cycle's pop plus
  // the read already in flight; capping it at 2 makes overflow impossible.
  always_comb begin
    occupancy = 3'(fifo_count) + 3'(inflight_reg) - 3'(pop);
    issue     = (state_reg == ST_FETCH) && !in_mem_write_busy && (occupancy < 3'd2);
    done_next = (state_reg == ST_DRAIN) && (occupancy == 3'd0);
    row_next  = row_reg;
    col_next  = col_reg;
    addr_next = addr_reg;
    if (start_ok) begin
      row_next  = '0;
      col_next  = '0;
      addr_next = block_addr(in_dy, '0, in_dx, '0);
    end else if (issue) begin
      if (col_reg == LAST_IDX) begin
        col_next = '0;
        row_next = blk_last ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
      // The final address is held so it never steps past the block.
      if (!blk_last) addr_next = block_addr(dy_reg, row_next, dx_reg, col_next);
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      dx_reg             <= '0;
      dy_reg             <= '0;
      row_reg            <= '0;
      col_reg            <= '0;
      addr_reg           <= '0;
      inflight_reg       <= 1'b0;
      inflight_first_reg <= 1'b0;
      inflight_last_reg  <= 1'b0;
      done_reg           <= 1'b0;
      err_reg            <= 1'b0;
    end else begin
      if (start_ok) begin
        dx_reg <= in_dx;
        dy_reg <= in_dy;
      end
      row_reg            <= row_next;
      col_reg            <= col_next;
      addr_reg           <= addr_next;
      inflight_reg       <= issue;
      inflight_first_reg <= issue && blk_first;
      inflight_last_reg  <= issue && blk_last;
      done_reg           <= done_next;
      err_reg            <= start_bad;
    end
  end

  fetch_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid_fifo (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_push  (inflight_reg),
    .in_data  (in_read_data),
    .in_first (inflight_first_reg),
    .in_last  (inflight_last_reg),
    .in_pop   (pop),
    .out_data (fifo_data),
    .out_first(fifo_first),
    .out_last (fifo_last),
    .out_valid(fifo_valid),
    .out_count(fifo_count)
  );

  assign out_read_addr   = addr_reg;
  assign out_pixel       = fifo_data;
  assign out_pixel_valid = fifo_valid;
  assign out_first       = fifo_first;
  assign out_last        = fifo_last;
  assign out_busy        = (state_reg != ST_IDLE);
  assign out_done        = done_reg;
  assign out_err         = err_reg;

endmodule

// File: tb/tb_ref_block_fetch.sv
// Directed bench for ref_block_fetch: memory holds mem[a] = a, each scenario
// task runs a block fetch and compares the captured stream to hand values.
module tb_ref_block_fetch;

  localparam int MD = 256;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b1;
  logic       in_start = 1'b0;
  logic [3:0] in_dx = 4'd0;
  logic [3:0] in_dy = 4'd0;
  logic       in_mem_write_busy = 1'b0;
  logic [7:0] out_read_addr;
  logic [7:0] in_read_data = 8'd0;
  logic [7:0] out_pixel;
  logic       out_pixel_valid;
  logic       in_pixel_ready = 1'b1;
  logic       out_first;
  logic       out_last;
  logic       out_busy;
  logic       out_done;
  logic       out_err;

  logic [7:0] mem [MD];
  logic [7:0] lfsr_reg = 8'hA5;

  int pix_q[$];
  bit first_q[$];
  bit last_q[$];
  int hs_cycle_q[$];
  int addr_trace[256];
  int done_cycle;
  bit busy_at_done;
  int drop_violations;

  int n_checks = 0;
  int n_fail = 0;

  ref_block_fetch dut (
    .in_clk           (in_clk),
    .in_rst           (in_rst),
    .in_start         (in_start),
    .in_dx            (in_dx),
    .in_dy            (in_dy),
    .in_mem_write_busy(in_mem_write_busy),
    .out_read_addr    (out_read_addr),
    .in_read_data     (in_read_data),
    .out_pixel        (out_pixel),
    .out_pixel_valid  (out_pixel_valid),
    .in_pixel_ready   (in_pixel_ready),
    .out_first        (out_first),
    .out_last         (out_last),
    .out_busy         (out_busy),
    .out_done         (out_done),
    .out_err          (out_err)
  );

  always #5 in_clk = ~in_clk;

  // Synchronous memory: 1-cycle read latency, no read while a write is active.
  always @(posedge in_clk) begin
    if (!in_mem_write_busy) in_read_data <= mem[out_read_addr];
  end

  // Start a block at cycle 0, then collect handshakes until done or budget.
  task automatic run_block(input int dx, input int dy, input bit rand_ready,
                           input int stall_start, input int stall_len,
                           input int restart_cycle, output bit timed_out);
    bit prev_valid;
    bit prev_ready;
    pix_q.delete();
    first_q.delete();
    last_q.delete();
    hs_cycle_q.delete();
    done_cycle = -1;
    busy_at_done = 1'b1;
    drop_violations = 0;
    timed_out = 1'b1;
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b1;
    in_dx = 4'(dx);
    in_dy = 4'(dy);
    in_pixel_ready = 1'b1;
    in_mem_write_busy = 1'b0;
    @(negedge in_clk);
    addr_trace[0] = int'(out_read_addr);
    for (int k = 1; k < 200; k++) begin
      @(posedge in_clk); #1;
      in_start = (k == restart_cycle);
      in_dx = (k == restart_cycle) ? 4'd12 : 4'(dx);
      in_mem_write_busy = (k >= stall_start) && (k < stall_start + stall_len);
      in_pixel_ready = rand_ready ? lfsr_reg[0] : 1'b1;
      lfsr_reg = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
      @(negedge in_clk);
      addr_trace[k] = int'(out_read_addr);
      if (prev_valid && !prev_ready && !out_pixel_valid) drop_violations++;
      if (out_pixel_valid && in_pixel_ready) begin
        pix_q.push_back(int'(out_pixel));
        first_q.push_back(out_first);
        last_q.push_back(out_last);
        hs_cycle_q.push_back(k);
        $display("  pixel #%0d: data=%0d first=%b last=%b cycle=%0d",
                 pix_q.size() - 1, out_pixel, out_first, out_last, k);
      end
      prev_valid = out_pixel_valid;
      prev_ready = in_pixel_ready;
      if (out_done) begin
        done_cycle = k;
        busy_at_done = out_busy;
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge in_clk); #1;
    in_start = 1'b0;
    in_pixel_ready = 1'b1;
    in_mem_write_busy = 1'b0;
  endtask

  task automatic test_reset();
    $display("test_reset");
    @(negedge in_clk);
    n_checks++;
    if (out_pixel_valid !== 1'b0 || out_busy !== 1'b0 || out_done !== 1'b0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid=%b busy=%b done=%b err=%b, want all 0",
               out_pixel_valid, out_busy, out_done, out_err);
    end
    n_checks++;
    if (out_read_addr !== 8'd0 || out_pixel !== 8'd0 || out_first !== 1'b0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%0d pixel=%0d first=%b last=%b, want 0",
               out_read_addr, out_pixel, out_first, out_last);
    end
    @(negedge in_clk);
    in_rst = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    int nf;
    int nl;
    $display("test_basic dx=0 dy=0");
    run_block(0, 0, 1'b0, 1000, 0, -1, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL basic_timeout: done not seen within budget"); end
    n_checks++;
    if (pix_q.size() != 16) begin n_fail++; $display("FAIL basic_count: got %0d pixels, want 16", pix_q.size()); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (i >= pix_q.size() || pix_q[i] != (i / 4) * 16 + (i % 4)) begin
        n_fail++;
        $display("FAIL basic_pixel[%0d]: got %0d want %0d", i, (i < pix_q.size()) ? pix_q[i] : -1,
                 (i / 4) * 16 + (i % 4));
      end
    end
    nf = 0;
    nl = 0;
    foreach (first_q[i]) nf += int'(first_q[i]);
    foreach (last_q[i]) nl += int'(last_q[i]);
    n_checks++;
    if (pix_q.size() != 16 || !first_q[0] || !last_q[15] || nf != 1 || nl != 1) begin
      n_fail++;
      $display("FAIL basic_tags: first_count=%0d last_count=%0d, want first only on pixel 0 and last only on pixel 15",
               nf, nl);
    end
    n_checks++;
    if (hs_cycle_q.size() != 16 || hs_cycle_q[0] != 3 || hs_cycle_q[15] != 18) begin
      n_fail++;
      $display("FAIL basic_latency: first/last handshake cycles %0d/%0d, want 3/18",
               (hs_cycle_q.size() > 0) ? hs_cycle_q[0] : -1, (hs_cycle_q.size() == 16) ? hs_cycle_q[15] : -1);
    end
    n_checks++;
    if (done_cycle != 19 || busy_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done cycle %0d busy=%b, want cycle 19 busy=0", done_cycle, busy_at_done);
    end
  endtask

  task automatic test_window_corner();
    bit to;
    int addr_list[$];
    int expv;
    $display("test_window_corner dx=12 dy=12");
    run_block(12, 12, 1'b0, 1000, 0, -1, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL corner_timeout: done not seen within budget"); end
    if (!to) begin
      addr_list.push_back(addr_trace[1]);
      for (int k = 2; k <= done_cycle; k++)
        if (addr_trace[k] != addr_list[addr_list.size() - 1]) addr_list.push_back(addr_trace[k]);
    end
    n_checks++;
    if (addr_list.size() != 16) begin
      n_fail++;
      $display("FAIL corner_addr_count: got %0d distinct addresses, want 16", addr_list.size());
    end
    for (int i = 0; i < 16; i++) begin
      expv = (12 + i / 4) * 16 + 12 + (i % 4);
      n_checks++;
      if (i >= addr_list.size() || addr_list[i] != expv) begin
        n_fail++;
        $display("FAIL corner_addr[%0d]: got %0d want %0d", i, (i < addr_list.size()) ? addr_list[i] : -1, expv);
      end
    end
    n_checks++;
    if (pix_q.size() != 16 || pix_q[15] != 255 || !last_q[15] || pix_q[0] != 204) begin
      n_fail++;
      $display("FAIL corner_stream: got %0d pixels first=%0d last=%0d, want 16 pixels 204..255",
               pix_q.size(), (pix_q.size() > 0) ? pix_q[0] : -1, (pix_q.size() > 0) ? pix_q[pix_q.size() - 1] : -1);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int expv;
    $display("test_backpressure dx=3 dy=5 random ready");
    run_block(3, 5, 1'b1, 1000, 0, -1, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL bp_timeout: done not seen within budget"); end
    n_checks++;
    if (pix_q.size() != 16) begin n_fail++; $display("FAIL bp_count: got %0d pixels, want 16", pix_q.size()); end
    for (int i = 0; i < 16; i++) begin
      expv = (5 + i / 4) * 16 + 3 + (i % 4);
      n_checks++;
      if (i >= pix_q.size() || pix_q[i] != expv) begin
        n_fail++;
        $display("FAIL bp_pixel[%0d]: got %0d want %0d", i, (i < pix_q.size()) ? pix_q[i] : -1, expv);
      end
    end
    n_checks++;
    if (drop_violations != 0) begin
      n_fail++;
      $display("FAIL bp_valid_drop: valid fell while ready=0 %0d times, want 0", drop_violations);
    end
  endtask

  task automatic test_write_stall();
    bit to;
    $display("test_write_stall write_busy cycles 5..7");
    run_block(0, 0, 1'b0, 5, 3, -1, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL stall_timeout: done not seen within budget"); end
    for (int k = 5; k <= 8; k++) begin
      n_checks++;
      if (addr_trace[k] != 16) begin
        n_fail++;
        $display("FAIL stall_addr_hold[cycle %0d]: got %0d want 16", k, addr_trace[k]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (i >= pix_q.size() || pix_q[i] != (i / 4) * 16 + (i % 4)) begin
        n_fail++;
        $display("FAIL stall_pixel[%0d]: got %0d want %0d", i, (i < pix_q.size()) ? pix_q[i] : -1,
                 (i / 4) * 16 + (i % 4));
      end
    end
    n_checks++;
    if (hs_cycle_q.size() != 16 || hs_cycle_q[15] != 21) begin
      n_fail++;
      $display("FAIL stall_delay: last handshake cycle %0d, want 21",
               (hs_cycle_q.size() == 16) ? hs_cycle_q[15] : -1);
    end
  endtask

  task automatic test_out_of_range();
    bit to;
    logic [7:0] prev_addr;
    $display("test_out_of_range dx=13 then dy=13 then valid start");
    for (int t = 0; t < 2; t++) begin
      @(negedge in_clk);
      prev_addr = out_read_addr;
      @(posedge in_clk); #1;
      in_start = 1'b1;
      in_dx = (t == 0) ? 4'd13 : 4'd0;
      in_dy = (t == 0) ? 4'd0 : 4'd13;
      @(posedge in_clk); #1;
      in_start = 1'b0;
      @(negedge in_clk);
      n_checks++;
      if (out_err !== 1'b1 || out_busy !== 1'b0 || out_read_addr !== prev_addr) begin
        n_fail++;
        $display("FAIL oor_reject[%0d]: err=%b busy=%b addr=%0d, want err=1 busy=0 addr=%0d",
                 t, out_err, out_busy, out_read_addr, prev_addr);
      end
      @(negedge in_clk);
      n_checks++;
      if (out_err !== 1'b0 || out_busy !== 1'b0 || out_read_addr !== prev_addr) begin
        n_fail++;
        $display("FAIL oor_after[%0d]: err=%b busy=%b addr=%0d, want err=0 busy=0 addr=%0d",
                 t, out_err, out_busy, out_read_addr, prev_addr);
      end
    end
    run_block(2, 1, 1'b0, 1000, 0, -1, to);
    n_checks++;
    if (to || pix_q.size() != 16 || pix_q[0] != 18 || pix_q[15] != 69) begin
      n_fail++;
      $display("FAIL oor_recover: timeout=%b count=%0d first=%0d last=%0d, want 16 pixels 18..69",
               to, pix_q.size(), (pix_q.size() > 0) ? pix_q[0] : -1,
               (pix_q.size() > 0) ? pix_q[pix_q.size() - 1] : -1);
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    $display("test_start_ignored restart pulse at cycle 5");
    run_block(0, 0, 1'b0, 1000, 0, 5, to);
    n_checks++;
    if (to || pix_q.size() != 16) begin
      n_fail++;
      $display("FAIL ignore_count: timeout=%b count=%0d, want 16 pixels", to, pix_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (i >= pix_q.size() || pix_q[i] != (i / 4) * 16 + (i % 4)) begin
        n_fail++;
        $display("FAIL ignore_pixel[%0d]: got %0d want %0d", i, (i < pix_q.size()) ? pix_q[i] : -1,
                 (i / 4) * 16 + (i % 4));
      end
    end
    @(negedge in_clk);
    n_checks++;
    if (out_busy !== 1'b0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_idle: busy=%b err=%b after done, want 0 0", out_busy, out_err);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int hs;
    $display("test_reset_mid reset after 7 pixels");
    @(posedge in_clk); #1;
    in_start = 1'b1;
    in_dx = 4'd0;
    in_dy = 4'd0;
    in_pixel_ready = 1'b1;
    @(posedge in_clk); #1;
    in_start = 1'b0;
    hs = 0;
    for (int k = 0; k < 50 && hs < 7; k++) begin
      @(negedge in_clk);
      if (out_pixel_valid && in_pixel_ready) hs++;
    end
    n_checks++;
    if (hs != 7) begin n_fail++; $display("FAIL rstmid_progress: got %0d pixels before reset, want 7", hs); end
    #2 in_rst = 1'b1;
    #1;
    n_checks++;
    if (out_pixel_valid !== 1'b0 || out_busy !== 1'b0 || out_read_addr !== 8'd0 ||
        out_pixel !== 8'd0 || out_first !== 1'b0 || out_last !== 1'b0 || out_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: valid=%b busy=%b addr=%0d pixel=%0d first=%b last=%b done=%b, want all 0",
               out_pixel_valid, out_busy, out_read_addr, out_pixel, out_first, out_last, out_done);
    end
    @(posedge in_clk);
    @(negedge in_clk);
    in_rst = 1'b0;
    run_block(0, 0, 1'b0, 1000, 0, -1, to);
    n_checks++;
    if (to || pix_q.size() != 16 || hs_cycle_q[0] != 3) begin
      n_fail++;
      $display("FAIL rstmid_restart: timeout=%b count=%0d first cycle=%0d, want 16 pixels from cycle 3",
               to, pix_q.size(), (hs_cycle_q.size() > 0) ? hs_cycle_q[0] : -1);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (i >= pix_q.size() || pix_q[i] != (i / 4) * 16 + (i % 4)) begin
        n_fail++;
        $display("FAIL rstmid_pixel[%0d]: got %0d want %0d", i, (i < pix_q.size()) ? pix_q[i] : -1,
                 (i / 4) * 16 + (i % 4));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < MD; a++) mem[a] = 8'(a);
    test_reset();
    test_basic();
    test_window_corner();
    test_backpressure();
    test_write_stall();
    test_out_of_range();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
